itcm_port_arbiter: RTL and testbench
====================================

Name: itcm_port_arbiter

Overview:
Arbiter and sequencer for the single-port ITCM SRAM shared by the IFU fetch path and the LSU.
- Accepts one request per cycle from either requester over valid/ready.
- Drives the SRAM (1-cycle read latency) and returns each response to its owner over valid/ready.
- Holds returned read data while the owner back-pressures.
- Sits between ifu_ifetch / LSU and the ITCM macro.

Parameters:
ITCM_AW, 14, SRAM word-address width; byte address bits [ITCM_AW+1:2] index the SRAM.
DW, 32, data and instruction width.
STARVE_MAX, 4, max consecutive LSU grants while IFU waits before IFU is forced.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ifu_req_valid  in  1  IFU fetch request
ifu_req_ready  out  1  IFU request accepted
ifu_req_pc  in  32  fetch byte address
ifu_rsp_valid  out  1  instruction returned
ifu_rsp_ready  in  1  IFU accepts instruction
ifu_rsp_instr  out  DW  fetched instruction
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted
lsu_req_read  in  1  1 = read, 0 = write
lsu_req_addr  in  32  byte address
lsu_req_wdata  in  DW  write data
lsu_req_wmask  in  DW/8  byte write enables
lsu_rsp_valid  out  1  LSU response (read data or write ack)
lsu_rsp_ready  in  1  LSU accepts response
lsu_rsp_rdata  out  DW  read data (0 for write acks)
itcm_cs  out  1  SRAM chip select
itcm_we  out  1  SRAM write enable
itcm_wem  out  DW/8  SRAM byte mask
itcm_addr  out  ITCM_AW  SRAM word address
itcm_wdata  out  DW  SRAM write data
itcm_rdata  in  DW  SRAM read data, valid one cycle after cs

Behaviour:
- Reset: all outputs 0; internal state is rsp_pend=0, rsp_own=IFU, hold=0, starve_cnt=0. Reset mid-transaction drops any pending response; no response is replayed.
- Only one outstanding access at a time. A grant is allowed when slot_free = ~rsp_pend | (rsp_pend & owner rsp_valid & owner rsp_ready). Back-to-back throughput is therefore 1 access/cycle when the owner accepts immediately.
- Arbitration, when slot_free and any request is valid:
  - LSU has priority, unless starve_cnt == STARVE_MAX and ifu_req_valid, in which case IFU is granted.
  - starve_cnt increments on each LSU grant while ifu_req_valid=1; it saturates at STARVE_MAX.
  - starve_cnt clears on any IFU grant, or on any cycle with ifu_req_valid=0.
- ready outputs are combinational: only the granted requester sees ready=1. ready is never asserted without a grant.
- Grant cycle:
  - itcm_cs=1.
  - itcm_addr = addr[ITCM_AW+1:2].
  - itcm_we = grant_lsu & ~lsu_req_read.
  - itcm_wem = wmask on a write, else 0.
  - itcm_wdata = lsu_req_wdata on a write, else 0.
  - Next cycle: rsp_pend=1, rsp_own=grantee, hold=0.
- Response:
  - Owner rsp_valid=1 whenever rsp_pend=1 and rsp_own matches.
  - The cycle after the grant, data comes directly from itcm_rdata and is simultaneously captured into rsp_buf.
  - If the response is not accepted that cycle, hold=1 and data comes from rsp_buf until the handshake.
  - Write acks drive rdata=0.
  - rsp_pend clears on handshake unless a new grant occurs in the same cycle.
- Latency: request accept to rsp_valid = 1 cycle.
- Simultaneous valid from both requesters with the slot busy and not draining: neither is granted; both ready=0.
- No flush input. The IFU discards unwanted responses by accepting them.
- Addresses outside the ITCM range are truncated (no error).

Test Plan:
- Single IFU fetch, pc=0x0000_0100, SRAM word 0x40 = 0x0010_0093, ifu_rsp_ready=1 -> itcm_cs=1, itcm_addr=0x40 in cycle 0; ifu_rsp_valid=1, instr=0x0010_0093 in cycle 1.
- LSU write addr=0x8, wdata=0xDEAD_BEEF, wmask=0xC, then LSU read addr=0x8 (prior word 0) -> itcm_we=1, itcm_wem=0xC; read returns 0xDEAD_0000; write ack rdata=0.
- Simultaneous IFU and LSU valid for 10 cycles, STARVE_MAX=4, both rsp_ready=1 -> grant pattern L,L,L,L,I,L,L,L,L,I.
- IFU response with ifu_rsp_ready held 0 for 3 cycles while itcm_rdata changes -> ifu_rsp_instr stays at the cycle-1 value; no grants until the handshake; next grant occurs in the handshake cycle.
- Back-to-back IFU fetches 0x0,0x4,0x8 with rsp_ready=1 -> 3 responses in 3 consecutive cycles, correct order.
- rst_n asserted low while rsp_pend=1 -> all rsp_valid=0 and itcm_cs=0 immediately; after release, no stale response.

Source files
------------

// File: rtl/itcm_port_arbiter.sv
// ITCM port arbiter: shares the single-port ITCM SRAM between IFU fetch and LSU.
// One access in flight at a time. The SRAM read data is forwarded the cycle
// after the grant and held in rsp_buf while the owner back-pressures.
module itcm_port_arbiter #(
  parameter int ITCM_AW    = 14,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ifu_req_valid,
  output logic                 ifu_req_ready,
  input  logic [31:0]          ifu_req_pc,
  output logic                 ifu_rsp_valid,
  input  logic                 ifu_rsp_ready,
  output logic [DW-1:0]        ifu_rsp_instr,
  input  logic                 lsu_req_valid,
  output logic                 lsu_req_ready,
  input  logic                 lsu_req_read,
  input  logic [31:0]          lsu_req_addr,
  input  logic [DW-1:0]        lsu_req_wdata,
  input  logic [DW/8-1:0]      lsu_req_wmask,
  output logic                 lsu_rsp_valid,
  input  logic                 lsu_rsp_ready,
  output logic [DW-1:0]        lsu_rsp_rdata,
  output logic                 itcm_cs,
  output logic                 itcm_we,
  output logic [DW/8-1:0]      itcm_wem,
  output logic [ITCM_AW-1:0]   itcm_addr,
  output logic [DW-1:0]        itcm_wdata,
  input  logic [DW-1:0]        itcm_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic {OWN_IFU = 1'b0, OWN_LSU = 1'b1} own_e;

  logic          rsp_pend;
  own_e          rsp_own;
  logic          hold;
  logic          rsp_wr;
  logic [DW-1:0] rsp_buf;
  logic [SW-1:0] starve_cnt;

  logic          starve_hit;
  logic          rsp_hs;
  logic          slot_free;
  logic          grant_lsu;
  logic          grant_ifu;
  logic          lsu_wr;
  logic [DW-1:0] rsp_data;
  logic [DW-1:0] rsp_out;

  // Address bits above the ITCM range and the byte offset are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ifu_req_pc[31:ITCM_AW+2], ifu_req_pc[1:0],
                              lsu_req_addr[31:ITCM_AW+2], lsu_req_addr[1:0]};

  assign starve_hit    = (starve_cnt == SW'(STARVE_MAX));
  assign ifu_rsp_valid = rsp_pend & (rsp_own == OWN_IFU);
  assign lsu_rsp_valid = rsp_pend & (rsp_own == OWN_LSU);
  assign rsp_hs        = (ifu_rsp_valid & ifu_rsp_ready) | (lsu_rsp_valid & lsu_rsp_ready);
  // Slot frees in the same cycle the owner takes its response, giving 1 access/cycle.
  assign slot_free     = ~rsp_pend | rsp_hs;
  // Grants are masked during reset so the SRAM is never selected while rst_n is low.
  assign grant_lsu     = rst_n & slot_free & lsu_req_valid & ~(starve_hit & ifu_req_valid);
  assign grant_ifu     = rst_n & slot_free & ifu_req_valid & ~grant_lsu;
  assign lsu_wr        = grant_lsu & ~lsu_req_read;

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;

  // First response cycle forwards SRAM data; afterwards the captured copy.
  assign rsp_data      = hold ? rsp_buf : itcm_rdata;
  assign rsp_out       = rsp_wr ? '0 : rsp_data;
  assign ifu_rsp_instr = ifu_rsp_valid ? rsp_out : '0;
  assign lsu_rsp_rdata = lsu_rsp_valid ? rsp_out : '0;

  // SRAM command for the granted requester; all zero when idle.
  always_comb begin
    itcm_cs    = 1'b0;
    itcm_we    = 1'b0;
    itcm_wem   = '0;
    itcm_addr  = '0;
    itcm_wdata = '0;
    if (grant_lsu) begin
      itcm_cs   = 1'b1;
      itcm_we   = lsu_wr;
      itcm_addr = lsu_req_addr[ITCM_AW+1:2];
      if (lsu_wr) begin
        itcm_wem   = lsu_req_wmask;
        itcm_wdata = lsu_req_wdata;
      end
    end else if (grant_ifu) begin
      itcm_cs   = 1'b1;
      itcm_addr = ifu_req_pc[ITCM_AW+1:2];
    end
  end

  // Outstanding-response tracking: pend/owner/hold/write-ack flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_pend <= 1'b0;
      rsp_own  <= OWN_IFU;
      hold     <= 1'b0;
      rsp_wr   <= 1'b0;
    end else if (grant_lsu || grant_ifu) begin
      rsp_pend <= 1'b1;
      rsp_own  <= grant_lsu ? OWN_LSU : OWN_IFU;
      hold     <= 1'b0;
      rsp_wr   <= lsu_wr;
    end else if (rsp_hs) begin
      rsp_pend <= 1'b0;
      hold     <= 1'b0;
    end else if (rsp_pend) begin
      hold     <= 1'b1;
    end
  end

  // Capture SRAM data in the first response cycle for use while held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               rsp_buf <= '0;
    else if (rsp_pend && !hold) rsp_buf <= itcm_rdata;
  end

  // Count LSU wins over a waiting IFU; saturate so IFU gets forced in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               starve_cnt <= '0;
    else if (!ifu_req_valid || grant_ifu)     starve_cnt <= '0;
    else if (grant_lsu && !starve_hit)        starve_cnt <= starve_cnt + 1'b1;
  end

endmodule

// File: tb/tb_itcm_port_arbiter.sv
// Directed bench for itcm_port_arbiter with a behavioural 1-cycle SRAM.
module tb_itcm_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
  logic [31:0] ifu_req_pc, ifu_rsp_instr;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_read, lsu_rsp_valid, lsu_rsp_ready;
  logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_rdata;
  logic [3:0]  lsu_req_wmask;
  logic        itcm_cs, itcm_we;
  logic [3:0]  itcm_wem;
  logic [13:0] itcm_addr;
  logic [31:0] itcm_wdata, itcm_rdata;

  always #5 clk = ~clk;

  itcm_port_arbiter #(.ITCM_AW(14), .DW(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_pc(ifu_req_pc),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_instr(ifu_rsp_instr),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_read(lsu_req_read),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_rdata(lsu_rsp_rdata),
    .itcm_cs(itcm_cs), .itcm_we(itcm_we), .itcm_wem(itcm_wem), .itcm_addr(itcm_addr),
    .itcm_wdata(itcm_wdata), .itcm_rdata(itcm_rdata)
  );

  // SRAM model, 1-cycle read latency; ovr_en lets a test scramble the read bus.
  logic [31:0] mem [0:16383];
  logic [31:0] rdata_q = '0;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_val = '0;
  always @(posedge clk) begin
    if (itcm_cs) begin
      if (itcm_we)
        for (int b = 0; b < 4; b++)
          if (itcm_wem[b]) mem[itcm_addr][b*8 +: 8] <= itcm_wdata[b*8 +: 8];
      rdata_q <= mem[itcm_addr];
    end
  end
  assign itcm_rdata = ovr_en ? ovr_val : rdata_q;

  typedef struct packed {
    logic iv; logic [31:0] pc; logic irr;
    logic lv; logic rd; logic [31:0] addr; logic [31:0] wd; logic [3:0] wm; logic lrr;
  } in_t;
  typedef struct packed {
    logic cs; logic we; logic [3:0] wem; logic [13:0] a; logic [31:0] wd;
    logic ir; logic lr; logic irv; logic [31:0] ins; logic lrv; logic [31:0] rd;
  } out_t;
  typedef struct packed { in_t i; out_t o; } vec_t;

  int checks = 0;
  int failures = 0;
  out_t act;
  assign act = {itcm_cs, itcm_we, itcm_wem, itcm_addr, itcm_wdata,
                ifu_req_ready, lsu_req_ready, ifu_rsp_valid, ifu_rsp_instr,
                lsu_rsp_valid, lsu_rsp_rdata};

  function automatic in_t mi(logic iv, logic [31:0] pc, logic irr, logic lv, logic rd,
                             logic [31:0] addr, logic [31:0] wd, logic [3:0] wm, logic lrr);
    return {iv, pc, irr, lv, rd, addr, wd, wm, lrr};
  endfunction
  function automatic out_t mo(logic cs, logic we, logic [3:0] wem, logic [13:0] a,
                              logic [31:0] wd, logic ir, logic lr, logic irv,
                              logic [31:0] ins, logic lrv, logic [31:0] rd);
    return {cs, we, wem, a, wd, ir, lr, irv, ins, lrv, rd};
  endfunction

  task automatic apply(input in_t v);
    ifu_req_valid = v.iv;  ifu_req_pc = v.pc;  ifu_rsp_ready = v.irr;
    lsu_req_valid = v.lv;  lsu_req_read = v.rd; lsu_req_addr = v.addr;
    lsu_req_wdata = v.wd;  lsu_req_wmask = v.wm; lsu_rsp_ready = v.lrr;
  endtask

  task automatic chk_all(input string nm, input out_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic cyc(input in_t v);
    @(posedge clk); #1;
    apply(v);
    @(negedge clk);
  endtask

  localparam in_t IDLE   = '0;
  localparam in_t IDLE_R = {1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1};

  vec_t vt [12];

  initial begin
    for (int k = 0; k < 16384; k++) mem[k] = '0;
    mem[14'h40] = 32'h0010_0093;
    mem[0]      = 32'h1111_1111;
    mem[1]      = 32'h2222_2222;

    // Single fetch, LSU write/read-back, back-to-back fetches.
    vt[0]  = '{IDLE,   mo(0,0,4'h0,14'h0,0, 0,0, 0,0, 0,0)};
    vt[1]  = '{mi(1,32'h100,1, 0,0,0,0,0,0), mo(1,0,4'h0,14'h40,0, 1,0, 0,0, 0,0)};
    vt[2]  = '{IDLE_R, mo(0,0,4'h0,14'h0,0, 0,0, 1,32'h0010_0093, 0,0)};
    vt[3]  = '{IDLE,   mo(0,0,4'h0,14'h0,0, 0,0, 0,0, 0,0)};
    vt[4]  = '{mi(0,0,0, 1,0,32'h8,32'hDEAD_BEEF,4'hC,1),
               mo(1,1,4'hC,14'h2,32'hDEAD_BEEF, 0,1, 0,0, 0,0)};
    vt[5]  = '{mi(0,0,0, 1,1,32'h8,32'h0,4'h0,1), mo(1,0,4'h0,14'h2,0, 0,1, 0,0, 1,0)};
    vt[6]  = '{IDLE_R, mo(0,0,4'h0,14'h0,0, 0,0, 0,0, 1,32'hDEAD_0000)};
    vt[7]  = '{mi(1,32'h0,1, 0,0,0,0,0,0), mo(1,0,4'h0,14'h0,0, 1,0, 0,0, 0,0)};
    vt[8]  = '{mi(1,32'h4,1, 0,0,0,0,0,0), mo(1,0,4'h0,14'h1,0, 1,0, 1,32'h1111_1111, 0,0)};
    vt[9]  = '{mi(1,32'h8,1, 0,0,0,0,0,0), mo(1,0,4'h0,14'h2,0, 1,0, 1,32'h2222_2222, 0,0)};
    vt[10] = '{IDLE_R, mo(0,0,4'h0,14'h0,0, 0,0, 1,32'hDEAD_0000, 0,0)};
    vt[11] = '{IDLE,   mo(0,0,4'h0,14'h0,0, 0,0, 0,0, 0,0)};

    // Reset with requests already asserted: nothing may reach the SRAM.
    rst_n = 1'b0;
    apply(mi(1,32'h100,1, 1,1,32'h8,0,0,1));
    #2;
    chk_all("reset_outputs", mo(0,0,4'h0,14'h0,0, 0,0, 0,0, 0,0));
    apply(IDLE);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      cyc(vt[i].i);
      chk_all($sformatf("vec%0d", i), vt[i].o);
    end

    // Both requesters valid for 10 cycles: L,L,L,L,I repeating.
    for (int i = 0; i < 10; i++) begin
      cyc(mi(1,32'h4,1, 1,1,32'h0,0,0,1));
      chk($sformatf("starve%0d", i), {30'h0, ifu_req_ready, lsu_req_ready},
          (i % 5 == 4) ? 32'h2 : 32'h1);
    end
    cyc(IDLE_R);
    cyc(IDLE);

    // Owner back-pressure: data held, no grants until the handshake.
    cyc(mi(1,32'h100,0, 0,0,0,0,0,0));
    chk("hold_grant", {31'h0, ifu_req_ready}, 32'h1);
    cyc(mi(1,32'h100,0, 1,1,32'h100,0,0,1));
    chk("hold_c1_instr", ifu_rsp_instr, 32'h0010_0093);
    chk("hold_c1_nogrant", {29'h0, itcm_cs, ifu_req_ready, lsu_req_ready}, 32'h0);
    for (int i = 2; i < 4; i++) begin
      @(posedge clk); #1;
      ovr_en = 1'b1; ovr_val = 32'hA5A5_0000 + i;
      @(negedge clk);
      chk($sformatf("hold_c%0d_instr", i), ifu_rsp_instr, 32'h0010_0093);
      chk($sformatf("hold_c%0d_nogrant", i), {29'h0, itcm_cs, ifu_req_ready, lsu_req_ready}, 32'h0);
    end
    cyc(mi(1,32'h100,1, 1,1,32'h100,0,0,1));
    chk("hold_hs_instr", {31'h0, ifu_rsp_valid} ^ 32'h0 | (ifu_rsp_instr == 32'h0010_0093 ? 32'h2 : 32'h0), 32'h3);
    chk("hold_hs_grant", {29'h0, itcm_cs, ifu_req_ready, lsu_req_ready}, 32'h5);
    @(posedge clk); #1;
    ovr_en = 1'b0;
    apply(IDLE_R);
    @(negedge clk);
    chk("hold_lsu_rsp", lsu_rsp_rdata, 32'h0010_0093);
    cyc(IDLE);

    // Reset while a response is pending: dropped, never replayed.
    cyc(mi(1,32'h100,0, 0,0,0,0,0,0));
    @(posedge clk); #1;
    chk("rst_pend_before", {31'h0, ifu_rsp_valid}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_pend_during", {28'h0, ifu_rsp_valid, lsu_rsp_valid, itcm_cs, ifu_req_ready}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    apply(IDLE_R);
    @(negedge clk);
    chk("rst_after0", {30'h0, ifu_rsp_valid, lsu_rsp_valid}, 32'h0);
    cyc(IDLE_R);
    chk("rst_after1", {30'h0, ifu_rsp_valid, lsu_rsp_valid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
